// File: rtl/board_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : board_pkg                                                    |
// | Description : Shared definitions for the board scanner: cell-state codes,  |
// |               board geometry, count width and scanner FSM encoding.        |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package board_pkg;

  // Board geometry
  localparam int N_CELLS = 16;
  localparam int CELL_W  = 2;
  localparam int BUS_W   = N_CELLS * CELL_W;

  // Counts must reach N_CELLS, hence one extra bit over log2(N_CELLS)
  localparam int CNT_W   = $clog2(N_CELLS) + 1;

  // Cell-state codes driven by the cell array
  localparam logic [CELL_W-1:0] CELL_EMPTY = 2'b00;
  localparam logic [CELL_W-1:0] CELL_SHIP  = 2'b01;
  localparam logic [CELL_W-1:0] CELL_MISS  = 2'b10;
  localparam logic [CELL_W-1:0] CELL_HIT   = 2'b11;

  // Scanner FSM encoding
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT    = 3'd1,
    S_CAPTURE = 3'd2,
    S_SCAN    = 3'd3,
    S_DONE    = 3'd4
  } state_t;

endpackage : board_pkg
`default_nettype wire

// File: rtl/cell_tally.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : cell_tally                                                   |
// | Description : Decodes one cell-state code into three one-hot increment     |
// |               enables (hit / miss / ship). EMPTY raises none of them.      |
// | Revision    : 1.0  initial release                                         |
// | Ports       : code_i  - cell-state code                                    |
// |               en_i    - qualifies the decode (scan in progress)            |
// |               hit_o   - cell is HIT                                        |
// |               miss_o  - cell is MISS                                       |
// |               ship_o  - cell is SHIP                                       |
// +----------------------------------------------------------------------------+
module cell_tally
  import board_pkg::*;
(
  input  logic [CELL_W-1:0] code_i,
  input  logic              en_i,
  output logic              hit_o,
  output logic              miss_o,
  output logic              ship_o
);

  always_comb begin
    hit_o  = 1'b0;
    miss_o = 1'b0;
    ship_o = 1'b0;
    if (en_i) begin
      case (code_i)
        CELL_SHIP: ship_o = 1'b1;
        CELL_MISS: miss_o = 1'b1;
        CELL_HIT:  hit_o  = 1'b1;
        default:   ;
      endcase
    end
  end

endmodule : cell_tally
`default_nettype wire

// File: rtl/board_scanner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : board_scanner                                                |
// | Description : After each accepted fire, waits SETTLE cycles, snapshots the |
// |               4x4 cell-state bus, walks the 16 cells one per clock and     |
// |               publishes hit / miss / ship counts, a saturating shot count  |
// |               and a sticky game_over flag.                                 |
// | Revision    : 1.0  initial release                                         |
// | Ports       : clk, reset (async, active-high)                              |
// |               board_state - live cell bus, CELL_W bits per cell            |
// |               fire, error - one-cycle fire pulse; ignored while error=1    |
// |               hits, misses, ships_left - counts from the last scan         |
// |               shots       - accepted fires, saturating                     |
// |               game_over   - sticky: hits>0 and no ships at end of a scan   |
// |               scan_valid  - one-cycle pulse when the counts update         |
// |               busy        - high whenever the FSM is not idle              |
// +----------------------------------------------------------------------------+
module board_scanner
  import board_pkg::*;
#(
  parameter int SETTLE = 2,
  parameter int SHOT_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [BUS_W-1:0]  board_state,
  input  logic              fire,
  input  logic              error,
  output logic [CNT_W-1:0]  hits,
  output logic [CNT_W-1:0]  misses,
  output logic [CNT_W-1:0]  ships_left,
  output logic [SHOT_W-1:0] shots,
  output logic              game_over,
  output logic              scan_valid,
  output logic              busy
);

  localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int IDX_W = $clog2(N_CELLS);

  state_t             state_q, state_d;
  logic [SET_W-1:0]   settle_q;
  logic [IDX_W-1:0]   idx_q;
  logic [BUS_W-1:0]   snap_q;
  logic [CNT_W-1:0]   hit_acc_q, miss_acc_q, ship_acc_q;
  logic [CNT_W-1:0]   hits_q, misses_q, ships_q;
  logic [SHOT_W-1:0]  shots_q;
  logic               game_over_q;
  logic               scan_valid_q;
  logic               pending_q;

  logic fire_ok;
  logic settle_done;
  logic scan_last;
  logic inc_hit, inc_miss, inc_ship;

  assign fire_ok     = fire && !error && !game_over_q;
  assign settle_done = (settle_q == SET_W'(SETTLE - 1));
  assign scan_last   = (idx_q == IDX_W'(N_CELLS - 1));

  // The snapshot is shifted right each scan cycle, so the current cell
  // always sits in the low CELL_W bits.
  cell_tally u_cell_tally (
    .code_i (snap_q[CELL_W-1:0]),
    .en_i   (state_q == S_SCAN),
    .hit_o  (inc_hit),
    .miss_o (inc_miss),
    .ship_o (inc_ship)
  );

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (fire_ok || pending_q) state_d = S_WAIT;
      S_WAIT:    if (settle_done)          state_d = S_CAPTURE;
      S_CAPTURE:                           state_d = S_SCAN;
      S_SCAN:    if (scan_last)            state_d = S_DONE;
      S_DONE:                              state_d = S_IDLE;
      default:                             state_d = S_IDLE;
    endcase
  end

  // Datapath: settle counter, snapshot shifter, accumulators, outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      settle_q     <= '0;
      idx_q        <= '0;
      snap_q       <= '0;
      hit_acc_q    <= '0;
      miss_acc_q   <= '0;
      ship_acc_q   <= '0;
      hits_q       <= '0;
      misses_q     <= '0;
      ships_q      <= '0;
      shots_q      <= '0;
      game_over_q  <= 1'b0;
      scan_valid_q <= 1'b0;
      pending_q    <= 1'b0;
    end else begin
      scan_valid_q <= 1'b0;

      // Every accepted fire counts, whatever the FSM is doing
      if (fire_ok && (shots_q != {SHOT_W{1'b1}})) begin
        shots_q <= shots_q + 1'b1;
      end

      // IDLE always consumes a pending request (it moves to WAIT), and a
      // fire seen in IDLE starts the scan directly, so only busy-time fires
      // are remembered.
      if (state_q == S_IDLE) begin
        pending_q <= 1'b0;
      end else if (fire_ok) begin
        pending_q <= 1'b1;
      end

      if (state_q == S_WAIT) begin
        settle_q <= settle_q + 1'b1;
      end else begin
        settle_q <= '0;
      end

      case (state_q)
        S_CAPTURE: begin
          snap_q     <= board_state;
          hit_acc_q  <= '0;
          miss_acc_q <= '0;
          ship_acc_q <= '0;
          idx_q      <= '0;
        end
        S_SCAN: begin
          snap_q     <= snap_q >> CELL_W;
          idx_q      <= idx_q + 1'b1;
          hit_acc_q  <= hit_acc_q  + CNT_W'(inc_hit);
          miss_acc_q <= miss_acc_q + CNT_W'(inc_miss);
          ship_acc_q <= ship_acc_q + CNT_W'(inc_ship);
        end
        S_DONE: begin
          hits_q       <= hit_acc_q;
          misses_q     <= miss_acc_q;
          ships_q      <= ship_acc_q;
          scan_valid_q <= 1'b1;
          if ((hit_acc_q != '0) && (ship_acc_q == '0)) begin
            game_over_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign hits       = hits_q;
  assign misses     = misses_q;
  assign ships_left = ships_q;
  assign shots      = shots_q;
  assign game_over  = game_over_q;
  assign scan_valid = scan_valid_q;
  assign busy       = (state_q != S_IDLE);

endmodule : board_scanner
`default_nettype wire

// File: tb/tb_board_scanner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_board_scanner                                             |
// | Description : Randomized and directed stimulus for board_scanner, checked  |
// |               every cycle against a timeline-based reference model.       |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_board_scanner;

  localparam int SETTLE  = 2;
  localparam int SHOT_W  = 8;
  localparam int SHOT_MX = (1 << SHOT_W) - 1;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              fire = 1'b0;
  logic              error = 1'b0;
  logic [31:0]       board_state = '0;
  logic [4:0]        hits, misses, ships_left;
  logic [SHOT_W-1:0] shots;
  logic              game_over, scan_valid, busy;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  board_scanner #(.SETTLE(SETTLE), .SHOT_W(SHOT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .board_state (board_state),
    .fire        (fire),
    .error       (error),
    .hits        (hits),
    .misses      (misses),
    .ships_left  (ships_left),
    .shots       (shots),
    .game_over   (game_over),
    .scan_valid  (scan_valid),
    .busy        (busy)
  );

  // Reference model: a scan started at edge s snapshots the board at edge
  // s+SETTLE+1 and publishes at edge s+SETTLE+18; busy covers the cycles in
  // between. Fires during a scan leave one request pending, which starts the
  // next scan on the edge after publication.
  int m_cyc, m_start;
  int m_hits, m_miss, m_ship, m_shots;
  int t_hits, t_miss, t_ship;
  bit m_active, m_pend, m_go, m_valid;

  task automatic model_clear();
    m_cyc = 0; m_start = 0;
    m_hits = 0; m_miss = 0; m_ship = 0; m_shots = 0;
    t_hits = 0; t_miss = 0; t_ship = 0;
    m_active = 0; m_pend = 0; m_go = 0; m_valid = 0;
  endtask

  task automatic model_edge();
    bit was_busy, acc;
    logic [31:0] b;
    if (reset) begin
      model_clear();
      return;
    end
    m_cyc++;
    was_busy = m_active;
    acc      = fire && !error && !m_go;
    m_valid  = 0;
    if (acc && m_shots != SHOT_MX) m_shots++;
    if (m_active && m_cyc == m_start + SETTLE + 1) begin
      b = board_state;
      t_hits = 0; t_miss = 0; t_ship = 0;
      for (int k = 0; k < 16; k++) begin
        case (b[2*k +: 2])
          2'b01: t_ship++;
          2'b10: t_miss++;
          2'b11: t_hits++;
          default: ;
        endcase
      end
    end
    if (m_active && m_cyc == m_start + SETTLE + 18) begin
      m_hits = t_hits; m_miss = t_miss; m_ship = t_ship;
      if (t_hits > 0 && t_ship == 0) m_go = 1;
      m_valid  = 1;
      m_active = 0;
    end
    if (was_busy) begin
      if (acc) m_pend = 1;
    end else if (acc || m_pend) begin
      m_active = 1;
      m_start  = m_cyc;
      m_pend   = 0;
    end
  endtask

  function automatic logic [31:0] pack_dut();
    return {6'b0, hits, misses, ships_left, shots, game_over, scan_valid, busy};
  endfunction

  function automatic logic [31:0] pack_mod();
    return {6'b0, 5'(m_hits), 5'(m_miss), 5'(m_ship), 8'(m_shots), m_go, m_valid, m_active};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t obs=%h exp=%h", tag, $time, obs, exp);
    end
  endtask

  // One clock: model follows the edge, outputs compared at the falling edge
  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_eq(tag, pack_dut(), pack_mod());
  endtask

  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  task automatic shoot(input string tag);
    fire = 1'b1;
    step(tag);
    fire = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_clear();
    @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic logic [31:0] put(input logic [31:0] b, input int k, input logic [1:0] c);
    logic [31:0] r;
    r = b;
    r[2*k +: 2] = c;
    return r;
  endfunction

  initial begin
    logic [31:0] b;
    model_clear();
    repeat (2) @(negedge clk);
    check_eq("reset_state", pack_dut(), 32'h0);
    reset = 1'b0;

    // All-empty board
    board_state = '0;
    shoot("empty_fire");
    run(SETTLE + 20, "empty_scan");

    // Ships at 0,5,15, miss at 2
    b = '0;
    b = put(b, 0, 2'b01); b = put(b, 5, 2'b01); b = put(b, 15, 2'b01); b = put(b, 2, 2'b10);
    board_state = b;
    shoot("ships_fire");
    run(SETTLE + 20, "ships_scan");

    // Fire masked by error
    error = 1'b1;
    shoot("err_fire");
    error = 1'b0;
    run(5, "err_idle");

    // Three fires during one scan, board changes mid-scan
    shoot("multi_fire0");
    run(6, "multi_a");
    board_state = put(board_state, 3, 2'b10);
    shoot("multi_fire1");
    run(2, "multi_b");
    shoot("multi_fire2");
    run(2, "multi_c");
    shoot("multi_fire3");
    run(50, "multi_tail");

    // Random traffic; cell 0 stays SHIP so the game never ends here
    for (int i = 0; i < 600; i++) begin
      fire  = ($urandom_range(0, 7) == 0);
      error = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 15) == 0) board_state = ($urandom & ~32'h3) | 32'h1;
      step("rand");
    end
    fire = 1'b0; error = 1'b0;
    run(45, "rand_tail");

    // Reset in the middle of a scan with a request pending
    shoot("rst_fire");
    run(SETTLE + 5, "rst_scan");
    shoot("rst_pend");
    run(2, "rst_scan2");
    reset = 1'b1;
    model_clear();
    #1;
    check_eq("rst_async", pack_dut(), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    run(40, "rst_after");

    // Shot counter saturation
    do_reset();
    fire = 1'b1;
    run(262, "sat_fire");
    fire = 1'b0;
    run(45, "sat_tail");
    check_eq("sat_value", 32'(shots), 32'(SHOT_MX));

    // Game over: all ships hit
    do_reset();
    b = '0;
    b = put(b, 0, 2'b11); b = put(b, 5, 2'b11); b = put(b, 15, 2'b11); b = put(b, 2, 2'b10);
    board_state = b;
    shoot("go_fire");
    run(SETTLE + 20, "go_scan");
    check_eq("go_flag", 32'(game_over), 32'd1);
    shoot("go_reject");
    run(5, "go_idle");
    check_eq("go_shots", 32'(shots), 32'd1);
    check_eq("go_busy", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule : tb_board_scanner
`default_nettype wire
